id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Second pipeline stage of the 5-stage LA32R core; sits directly downstream of the fetch stage and upstream of EX.
- Latches the {pc, inst} bus from fetch and decodes the instruction.
- Reads the external register file and resolves branches and jumps in-stage, driving the branch bus back to nextpc generation.
- Detects RAW hazards and stalls on them, then hands a packed control/operand bus to EX using the valid/allow_in handshake.

Parameters:
- DATA_W, 32, datapath/register width.
- REG_ADDR_W, 5, register-file address width (32 GPRs, r0 hardwired zero).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- IF_to_ID_valid  input  1  fetch holds a valid instruction.
- to_ID_data  input  `to_ID_data_width (64)  {pc[31:0], inst[31:0]}.
- ID_allow_in  output  1  ID can accept from fetch this cycle.
- EX_allow_in  input  1  EX can accept this cycle.
- ID_to_EX_valid  output  1  ID offers a valid instruction to EX.
- to_EX_data  output  `to_EX_data_width (148)  {pc32, alu_op12, src1 32, src2 32, rkd_value32, dest5, gr_we1, mem_we1, res_from_mem1}.
- br_taken  output  1  redirect fetch this cycle.
- br_target  output  32  redirect target.
- rf_raddr1, rf_raddr2  output  5 each  regfile read addresses.
- rf_rdata1, rf_rdata2  input  32 each  combinational read data.
- EX_dest, MEM_dest, WB_dest  input  5 each  destination register of a valid, gr_we instruction in that stage; 0 means none.
- EX_is_load  input  1  EX holds ld.w.
- EX_fwd, MEM_fwd, WB_fwd  input  32 each  result values for bypass; used only under ID_BYPASS_EN.

Behaviour:
- Reset: ID_valid=0, latched pc/inst=0, br_taken=0, ID_to_EX_valid=0.
- Handshake:
  - ID_allow_in = ~ID_valid | (ID_ready_go & EX_allow_in).
  - ID_to_EX_valid = ID_valid & ID_ready_go.
  - fire = ID_to_EX_valid & EX_allow_in.
- Latch: when ID_allow_in, ID_valid <= IF_to_ID_valid & ~br_flush, and {pc, inst} <= to_ID_data (only if IF_to_ID_valid). br_flush is defined under Branches.
- Decode subset, encodings per LA32R manual:
  - add.w, sub.w, slt, sltu, and, or, nor, xor
  - slli.w, srli.w, srai.w, addi.w, lu12i.w
  - ld.w, st.w
  - jirl, b, bl, beq, bne
  - Unknown opcode decodes as a NOP: gr_we=0, mem_we=0.
- Register reads: rf_raddr1=rj; rf_raddr2 = rd for st.w/beq/bne, otherwise rk.
- Operands:
  - src1 = pc for bl/jirl, otherwise rj value.
  - src2 = sign-extended si12 (addi.w, ld.w, st.w); zero-extended ui5 (shifts); si20<<12 (lu12i.w); 4 (bl, jirl); otherwise rk value.
  - rkd_value = read port 2 value.
- Destination: dest = 1 for bl, otherwise rd. gr_we=0 for st/beq/bne/b. dest is forced to 0 when gr_we=0.
- Branches:
  - offs16 or offs26 is sign-extended and shifted left 2. Target = pc+offs for b/bl/beq/bne; target = rj+offs16<<2 for jirl.
  - beq/bne compare the full 32-bit resolved operands.
  - br_taken = fire & taken. br_taken is combinational in the fire cycle only.
  - br_flush is a registered copy of br_taken. It squashes the single sequential instruction fetched behind the branch: that instruction latches with ID_valid=0.
  - If fire does not occur (stall), br_taken stays 0 and is re-evaluated every cycle.
- Hazard, no bypass:
  - ID_ready_go = 0 while any nonzero source register in use matches a nonzero EX_dest, MEM_dest or WB_dest.
  - r0 never stalls.
  - Sources not used by the instruction are ignored (e.g. lu12i.w, b).
- Stall: ID holds pc/inst and all outputs stable. br_taken stays 0 during the stall.
- Reset mid-stall: valid clears next edge and the held instruction is dropped.

Optional Feature:
- Macro: ID_BYPASS_EN.
- Defined:
  - Operand values are selected with priority EX_fwd > MEM_fwd > WB_fwd > rf_rdata on nonzero dest match.
  - ID_ready_go = 0 only when EX_is_load and EX_dest matches a used source (load-use, 1-cycle bubble).
  - EX_fwd/MEM_fwd/WB_fwd inputs exist.
- Undefined: the stall-only behaviour above applies and the three *_fwd ports are absent.

Decomposition:
- constants.h (shared):
  - `to_ID_data_width = 64, `to_EX_data_width = 148.
  - alu_op one-hot bit indices (add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui).
- Sub-module id_decoder: purely combinational. Maps inst to the one-hot instruction flags, alu_op, immediate select, and src/dest usage flags.
- id_stage keeps the pipeline register, hazard/bypass logic and branch resolution.

Test Plan:
1. Reset, then IF_to_ID_valid=1, pc=0x1c000000, inst=0x02801401 (addi.w r1,r0,5), EX_allow_in=1 -> next cycle ID_to_EX_valid=1, src1=0, src2=5, dest=1, gr_we=1, alu_op=add.
2. beq r1,r2 (inst 0x58001022) at pc 0x1c000010, rf_rdata1=rf_rdata2=7 -> br_taken=1 with br_target=0x1c000020. Following instruction pc 0x1c000014 is latched with ID_valid=0.
3. Same beq with rdata 7 vs 8 -> br_taken=0, no flush, next instruction passes normally.
4. EX_dest=1, ID holds add.w r3,r1,r2, no macro -> ID_ready_go=0 and ID_allow_in=0 until EX/MEM/WB_dest all differ from 1, then fires with the rf value.
5. ID_BYPASS_EN, EX_dest=1, EX_is_load=1 -> exactly 1 stall cycle. Next cycle MEM_dest=1, MEM_fwd=0x1234 -> src1=0x1234.
6. EX_allow_in=0 for 3 cycles with a valid bl at 0x1c000100 -> outputs stable and br_taken=0. On release, br_taken=1, target pc+offs, dest=1, src1=0x1c000100, src2=4.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared constants and decode types for the LA32R ID stage.
package id_stage_pkg;

  localparam int unsigned TO_ID_DATA_WIDTH = 64;
  localparam int unsigned TO_EX_DATA_WIDTH = 148;

  localparam int unsigned ALU_OP_W = 12;
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  typedef enum logic [2:0] {
    SRC2_RK,
    SRC2_SI12,
    SRC2_UI5,
    SRC2_SI20,
    SRC2_FOUR
  } src2_sel_e;

  typedef struct packed {
    logic                jirl;
    logic                b;
    logic                bl;
    logic                beq;
    logic                bne;
    logic                ld;
    logic                st;
    logic [ALU_OP_W-1:0] alu_op;
    src2_sel_e           src2_sel;
    logic                src1_is_pc;
    logic                use_rj;
    logic                use_rk;
    logic                src2_is_rd;
    logic                gr_we;
    logic                dest_is_r1;
  } dec_t;

  localparam int unsigned DEC_W = $bits(dec_t);

endpackage

// File: rtl/id_stage_decoder.sv
// Combinational LA32R opcode decoder for the ID stage; input is inst[31:15].
module id_decoder
  import id_stage_pkg::*;
(
  input  logic [16:0]      opcode,
  output logic [DEC_W-1:0] dec_bits
);

  dec_t d;
  logic op_add, op_sub, op_slt, op_sltu, op_and, op_or, op_nor, op_xor;
  logic op_slli, op_srli, op_srai, op_addi, op_lu12i, op_ld, op_st;
  logic op_jirl, op_b, op_bl, op_beq, op_bne;
  logic is_3r, is_shift;

  assign op_add   = opcode == 17'h00020;
  assign op_sub   = opcode == 17'h00022;
  assign op_slt   = opcode == 17'h00024;
  assign op_sltu  = opcode == 17'h00025;
  assign op_nor   = opcode == 17'h00028;
  assign op_and   = opcode == 17'h00029;
  assign op_or    = opcode == 17'h0002a;
  assign op_xor   = opcode == 17'h0002b;
  assign op_slli  = opcode == 17'h00081;
  assign op_srli  = opcode == 17'h00089;
  assign op_srai  = opcode == 17'h00091;
  assign op_addi  = opcode[16:7]  == 10'h00a;
  assign op_ld    = opcode[16:7]  == 10'h0a2;
  assign op_st    = opcode[16:7]  == 10'h0a6;
  assign op_lu12i = opcode[16:10] == 7'h0a;
  assign op_jirl  = opcode[16:11] == 6'h13;
  assign op_b     = opcode[16:11] == 6'h14;
  assign op_bl    = opcode[16:11] == 6'h15;
  assign op_beq   = opcode[16:11] == 6'h16;
  assign op_bne   = opcode[16:11] == 6'h17;

  assign is_3r    = op_add | op_sub | op_slt | op_sltu | op_and | op_or | op_nor | op_xor;
  assign is_shift = op_slli | op_srli | op_srai;

  always_comb begin
    d = '0;
    d.jirl = op_jirl;
    d.b    = op_b;
    d.bl   = op_bl;
    d.beq  = op_beq;
    d.bne  = op_bne;
    d.ld   = op_ld;
    d.st   = op_st;

    d.alu_op[ALU_ADD]  = op_add | op_addi | op_ld | op_st | op_jirl | op_bl;
    d.alu_op[ALU_SUB]  = op_sub;
    d.alu_op[ALU_SLT]  = op_slt;
    d.alu_op[ALU_SLTU] = op_sltu;
    d.alu_op[ALU_AND]  = op_and;
    d.alu_op[ALU_NOR]  = op_nor;
    d.alu_op[ALU_OR]   = op_or;
    d.alu_op[ALU_XOR]  = op_xor;
    d.alu_op[ALU_SLL]  = op_slli;
    d.alu_op[ALU_SRL]  = op_srli;
    d.alu_op[ALU_SRA]  = op_srai;
    d.alu_op[ALU_LUI]  = op_lu12i;

    d.src2_sel = SRC2_RK;
    if (op_addi | op_ld | op_st) d.src2_sel = SRC2_SI12;
    else if (is_shift)           d.src2_sel = SRC2_UI5;
    else if (op_lu12i)           d.src2_sel = SRC2_SI20;
    else if (op_bl | op_jirl)    d.src2_sel = SRC2_FOUR;

    d.src1_is_pc = op_bl | op_jirl;
    d.use_rj     = is_3r | is_shift | op_addi | op_ld | op_st | op_jirl | op_beq | op_bne;
    d.use_rk     = is_3r;
    d.src2_is_rd = op_st | op_beq | op_bne;
    d.gr_we      = is_3r | is_shift | op_addi | op_lu12i | op_ld | op_jirl | op_bl;
    d.dest_is_r1 = op_bl;
  end

  assign dec_bits = d;

endmodule

// File: rtl/id_stage.sv
// LA32R decode stage: pipeline register, RAW hazard handling, in-stage branch resolution.
// Optional operand bypass from EX/MEM/WB is enabled by defining ID_BYPASS_EN.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        IF_to_ID_valid,
  input  logic [TO_ID_DATA_WIDTH-1:0] to_ID_data,
  output logic                        ID_allow_in,
  input  logic                        EX_allow_in,
  output logic                        ID_to_EX_valid,
  output logic [TO_EX_DATA_WIDTH-1:0] to_EX_data,
  output logic                        br_taken,
  output logic [31:0]                 br_target,
  output logic [REG_ADDR_W-1:0]       rf_raddr1,
  output logic [REG_ADDR_W-1:0]       rf_raddr2,
  input  logic [DATA_W-1:0]           rf_rdata1,
  input  logic [DATA_W-1:0]           rf_rdata2,
  input  logic [REG_ADDR_W-1:0]       EX_dest,
  input  logic [REG_ADDR_W-1:0]       MEM_dest,
  input  logic [REG_ADDR_W-1:0]       WB_dest,
  input  logic                        EX_is_load
`ifdef ID_BYPASS_EN
  ,
  input  logic [DATA_W-1:0]           EX_fwd,
  input  logic [DATA_W-1:0]           MEM_fwd,
  input  logic [DATA_W-1:0]           WB_fwd
`endif
);

  logic                  id_valid, br_flush, ready_go, fire, taken, use2;
  logic [31:0]           pc, inst, offs16, offs26;
  logic [DATA_W-1:0]     rj_val, r2_val, src1, src2;
  logic [REG_ADDR_W-1:0] rj, rk, rd, dest;
  logic [DEC_W-1:0]      dec_bits;
  dec_t                  dec;

  id_decoder u_decoder (
    .opcode   (inst[31:15]),
    .dec_bits (dec_bits)
  );
  assign dec = dec_t'(dec_bits);

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid <= 1'b0;
      br_flush <= 1'b0;
      pc       <= '0;
      inst     <= '0;
    end else begin
      br_flush <= br_taken;
      if (ID_allow_in) begin
        id_valid <= IF_to_ID_valid & ~br_flush;
        if (IF_to_ID_valid) {pc, inst} <= to_ID_data;
      end
    end
  end

  assign rj        = inst[9:5];
  assign rk        = inst[14:10];
  assign rd        = inst[4:0];
  assign rf_raddr1 = rj;
  assign rf_raddr2 = dec.src2_is_rd ? rd : rk;
  assign use2      = dec.use_rk | dec.src2_is_rd;

  function automatic logic hit(input logic en, input logic [REG_ADDR_W-1:0] r,
                               input logic [REG_ADDR_W-1:0] dst);
    return en && (r != '0) && (r == dst);
  endfunction

`ifdef ID_BYPASS_EN
  function automatic logic [DATA_W-1:0] pick(input logic [REG_ADDR_W-1:0] r,
                                             input logic [DATA_W-1:0] rdata,
                                             input logic [REG_ADDR_W-1:0] ed, md, wd,
                                             input logic [DATA_W-1:0] ef, mf, wf);
    if (hit(1'b1, r, ed)) return ef;
    if (hit(1'b1, r, md)) return mf;
    if (hit(1'b1, r, wd)) return wf;
    return rdata;
  endfunction

  assign rj_val   = pick(rf_raddr1, rf_rdata1, EX_dest, MEM_dest, WB_dest, EX_fwd, MEM_fwd, WB_fwd);
  assign r2_val   = pick(rf_raddr2, rf_rdata2, EX_dest, MEM_dest, WB_dest, EX_fwd, MEM_fwd, WB_fwd);
  // Only a load in EX cannot be bypassed yet; everything else forwards.
  assign ready_go = ~(EX_is_load & (hit(dec.use_rj, rj, EX_dest) | hit(use2, rf_raddr2, EX_dest)));
`else
  logic unused_is_load;
  assign unused_is_load = EX_is_load;
  assign rj_val   = rf_rdata1;
  assign r2_val   = rf_rdata2;
  assign ready_go = ~(hit(dec.use_rj, rj, EX_dest) | hit(dec.use_rj, rj, MEM_dest) |
                      hit(dec.use_rj, rj, WB_dest) | hit(use2, rf_raddr2, EX_dest) |
                      hit(use2, rf_raddr2, MEM_dest) | hit(use2, rf_raddr2, WB_dest));
`endif

  assign ID_allow_in    = ~id_valid | (ready_go & EX_allow_in);
  assign ID_to_EX_valid = id_valid & ready_go;
  assign fire           = ID_to_EX_valid & EX_allow_in;

  assign offs16    = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26    = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign taken     = dec.jirl | dec.b | dec.bl |
                     (dec.beq & (rj_val == r2_val)) | (dec.bne & (rj_val != r2_val));
  assign br_taken  = fire & taken;
  assign br_target = dec.jirl ? rj_val + offs16 :
                     (dec.b | dec.bl) ? pc + offs26 : pc + offs16;

  assign src1 = dec.src1_is_pc ? pc : rj_val;

  always_comb begin
    src2 = r2_val;
    case (dec.src2_sel)
      SRC2_SI12: src2 = {{20{inst[21]}}, inst[21:10]};
      SRC2_UI5:  src2 = {27'b0, inst[14:10]};
      SRC2_SI20: src2 = {inst[24:5], 12'b0};
      SRC2_FOUR: src2 = 32'd4;
      default:   src2 = r2_val;
    endcase
  end

  assign dest = dec.gr_we ? (dec.dest_is_r1 ? 5'd1 : rd) : '0;

  assign to_EX_data = {pc, dec.alu_op, src1, src2, r2_val, dest, dec.gr_we, dec.st, dec.ld};

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios then randomized traffic against a reference model.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset, IF_to_ID_valid, EX_allow_in, EX_is_load;
  logic [63:0]  to_ID_data;
  logic         ID_allow_in, ID_to_EX_valid, br_taken;
  logic [147:0] to_EX_data;
  logic [31:0]  br_target, rf_rdata1, rf_rdata2;
  logic [4:0]   rf_raddr1, rf_raddr2, EX_dest, MEM_dest, WB_dest;
  logic [31:0]  EX_fwd, MEM_fwd, WB_fwd;
  logic [31:0]  regs [32];

  always #5 clk = ~clk;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  id_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .IF_to_ID_valid(IF_to_ID_valid), .to_ID_data(to_ID_data),
    .ID_allow_in(ID_allow_in), .EX_allow_in(EX_allow_in), .ID_to_EX_valid(ID_to_EX_valid),
    .to_EX_data(to_EX_data), .br_taken(br_taken), .br_target(br_target),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .EX_dest(EX_dest), .MEM_dest(MEM_dest), .WB_dest(WB_dest), .EX_is_load(EX_is_load)
`ifdef ID_BYPASS_EN
    , .EX_fwd(EX_fwd), .MEM_fwd(MEM_fwd), .WB_fwd(WB_fwd)
`endif
  );

  // Instruction kinds: 0..7 three-register ALU, 8..10 shifts, 11 addi, 12 lu12i, 13 ld,
  // 14 st, 15 jirl, 16 b, 17 bl, 18 beq, 19 bne, 20 anything else.
  localparam logic [31:0] K_MASK [20] = '{
    32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000,
    32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFFF8000, 32'hFFC00000,
    32'hFE000000, 32'hFFC00000, 32'hFFC00000, 32'hFC000000, 32'hFC000000, 32'hFC000000,
    32'hFC000000, 32'hFC000000};
  localparam logic [31:0] K_MATCH [20] = '{
    32'h00100000, 32'h00110000, 32'h00120000, 32'h00128000, 32'h00148000, 32'h00150000,
    32'h00140000, 32'h00158000, 32'h00408000, 32'h00448000, 32'h00488000, 32'h02800000,
    32'h14000000, 32'h28800000, 32'h29800000, 32'h4C000000, 32'h50000000, 32'h54000000,
    32'h58000000, 32'h5C000000};
  // add sub slt sltu and or nor xor slli srli srai addi lu12i ld st jirl b bl beq bne other
  localparam int K_ALU [21] = '{0, 1, 2, 3, 4, 6, 5, 7, 8, 9, 10, 0, 11, 0, 0, 0, -1, 0, -1, -1, -1};

  int n_pass = 0, n_total = 0;

  logic         m_valid, m_flush, n_valid, n_flush;
  logic [31:0]  m_pc, m_inst, n_pc, n_inst;
  logic         e_allow, e_v2ex, e_brt;
  logic [4:0]   e_raddr1, e_raddr2;
  logic [31:0]  e_target;
  logic [147:0] e_data;

  task automatic check(input string tag, input logic [147:0] act, input logic [147:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic int kind_of(input logic [31:0] inst);
    for (int i = 0; i < 20; i++)
      if ((inst & K_MASK[i]) == K_MATCH[i]) return i;
    return 20;
  endfunction

  function automatic logic [31:0] val(input logic [4:0] r);
`ifdef ID_BYPASS_EN
    if (r != 0 && r == EX_dest)  return EX_fwd;
    if (r != 0 && r == MEM_dest) return MEM_fwd;
    if (r != 0 && r == WB_dest)  return WB_fwd;
`endif
    return regs[r];
  endfunction

  function automatic bit busy(input logic [4:0] r);
    return r != 0 && (r == EX_dest || r == MEM_dest || r == WB_dest);
  endfunction

  function automatic int sext(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  task automatic model_eval();
    int k = kind_of(m_inst);
    logic [4:0] rj = m_inst[9:5], rk = m_inst[14:10], rd = m_inst[4:0], r2;
    bit use_j, r2_rd, use_2, ready, gr_we, taken;
    logic [31:0] vj, v2, s1, s2;
    logic [11:0] alu;
    logic [4:0] dest;
    int o16, o26;
    use_j = !(k == 12 || k == 16 || k == 17 || k == 20);
    r2_rd = (k == 14 || k == 18 || k == 19);
    use_2 = (k <= 7) || r2_rd;
    r2 = r2_rd ? rd : rk;
    vj = val(rj);
    v2 = val(r2);
`ifdef ID_BYPASS_EN
    ready = !(EX_is_load && EX_dest != 0 && ((use_j && rj == EX_dest) || (use_2 && r2 == EX_dest)));
`else
    ready = !((use_j && busy(rj)) || (use_2 && busy(r2)));
`endif
    o16 = sext(int'(m_inst[25:10]), 16) * 4;
    o26 = sext(int'({m_inst[9:0], m_inst[25:10]}), 26) * 4;
    s1 = (k == 15 || k == 17) ? m_pc : vj;
    if (k == 11 || k == 13 || k == 14) s2 = sext(int'(m_inst[21:10]), 12);
    else if (k >= 8 && k <= 10)        s2 = 32'(m_inst[14:10]);
    else if (k == 12)                  s2 = 32'(m_inst[24:5]) * 4096;
    else if (k == 15 || k == 17)       s2 = 4;
    else                               s2 = v2;
    alu   = (K_ALU[k] < 0) ? 12'h000 : (12'h001 << K_ALU[k]);
    gr_we = !(k == 14 || k == 16 || k == 18 || k == 19 || k == 20);
    dest  = !gr_we ? 5'd0 : (k == 17) ? 5'd1 : rd;
    taken = (k == 15 || k == 16 || k == 17) || (k == 18 && vj == v2) || (k == 19 && vj != v2);
    e_target = (k == 15) ? vj + o16 : (k == 16 || k == 17) ? m_pc + o26 : m_pc + o16;
    e_raddr1 = rj;
    e_raddr2 = r2;
    e_allow  = !m_valid || (ready && EX_allow_in);
    e_v2ex   = m_valid && ready;
    e_brt    = e_v2ex && EX_allow_in && taken;
    e_data   = {m_pc, alu, s1, s2, v2, dest, gr_we, k == 14, k == 13};
  endtask

  // Checks the current cycle at mid-period and works out the model's next state.
  task automatic step();
    #4;
    model_eval();
    check("allow_in", ID_allow_in, e_allow);
    check("to_ex_valid", ID_to_EX_valid, e_v2ex);
    check("br_taken", br_taken, e_brt);
    check("raddr1", rf_raddr1, e_raddr1);
    check("raddr2", rf_raddr2, e_raddr2);
    if (e_v2ex) check("to_EX_data", to_EX_data, e_data);
    if (e_brt)  check("br_target", br_target, e_target);
    n_valid = m_valid; n_pc = m_pc; n_inst = m_inst; n_flush = e_brt;
    if (reset) begin
      n_valid = 0; n_pc = 0; n_inst = 0; n_flush = 0;
    end else if (e_allow) begin
      n_valid = IF_to_ID_valid && !m_flush;
      if (IF_to_ID_valid) {n_pc, n_inst} = to_ID_data;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_valid = n_valid; m_pc = n_pc; m_inst = n_inst; m_flush = n_flush;
  endtask

  task automatic idle();
    reset = 0; IF_to_ID_valid = 0; EX_allow_in = 1; EX_is_load = 0;
    EX_dest = 0; MEM_dest = 0; WB_dest = 0;
    to_ID_data = '0; EX_fwd = 0; MEM_fwd = 0; WB_fwd = 0;
  endtask

  function automatic logic [31:0] gen_inst();
    int k = $urandom_range(0, 20);
    logic [31:0] r = $urandom;
    logic [31:0] inst;
    if (k == 20) return {6'h3f, r[25:0]};
    inst = K_MATCH[k] | (r & ~K_MASK[k]);
    inst[9:5] = 5'($urandom_range(0, 3));
    inst[4:0] = 5'($urandom_range(0, 3));
    if (k <= 7) inst[14:10] = 5'($urandom_range(0, 3));
    return inst;
  endfunction

  logic [147:0] held;
  logic [31:0]  rpc;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h01010101;
    idle();
    reset = 1;
    @(posedge clk); #1;
    m_valid = 0; m_pc = 0; m_inst = 0; m_flush = 0;
    step();
    check("rst_to_ex_valid", ID_to_EX_valid, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_allow_in", ID_allow_in, 1);
    advance();

    // addi.w r1,r0,5
    idle(); IF_to_ID_valid = 1; to_ID_data = {32'h1c000000, 32'h02801401};
    step(); advance();
    idle(); step();
    check("t1_valid", ID_to_EX_valid, 1);
    check("t1_src1", to_EX_data[103:72], 0);
    check("t1_src2", to_EX_data[71:40], 5);
    check("t1_dest", to_EX_data[7:3], 1);
    check("t1_gr_we", to_EX_data[2], 1);
    check("t1_alu_op", to_EX_data[115:104], 12'h001);
    advance();

    // beq r1,r2 taken, then squash of the next fetched instruction
    regs[1] = 7; regs[2] = 7;
    idle(); IF_to_ID_valid = 1; to_ID_data = {32'h1c000010, 32'h58001022};
    step(); advance();
    idle(); step();
    check("t2_br_taken", br_taken, 1);
    check("t2_br_target", br_target, 32'h1c000020);
    advance();
    idle(); IF_to_ID_valid = 1; to_ID_data = {32'h1c000014, 32'h02801401};
    step(); advance();
    idle(); step();
    check("t2_squashed", ID_to_EX_valid, 0);
    advance();

    // beq not taken; next instruction flows normally
    regs[2] = 8;
    idle(); IF_to_ID_valid = 1; to_ID_data = {32'h1c000010, 32'h58001022};
    step(); advance();
    idle(); IF_to_ID_valid = 1; to_ID_data = {32'h1c000014, 32'h02801401};
    step();
    check("t3_br_taken", br_taken, 0);
    advance();
    idle(); step();
    check("t3_next_valid", ID_to_EX_valid, 1);
    check("t3_next_pc", to_EX_data[147:116], 32'h1c000014);
    advance();

    // add.w r3,r1,r2 against producers walking down the pipe
    idle(); IF_to_ID_valid = 1; to_ID_data = {32'h1c000020, 32'h00100823};
    step(); advance();
    idle(); EX_dest = 1; step();
`ifndef ID_BYPASS_EN
    check("t4_stall_allow", ID_allow_in, 0);
    check("t4_stall_valid", ID_to_EX_valid, 0);
`endif
    advance();
    idle(); MEM_dest = 1; step(); advance();
    idle(); WB_dest = 1; step(); advance();
    idle(); step();
    check("t4_fire", ID_to_EX_valid, 1);
    check("t4_src1", to_EX_data[103:72], 7);
    advance();

`ifdef ID_BYPASS_EN
    // load-use: one bubble, then forwarded from MEM
    idle(); IF_to_ID_valid = 1; to_ID_data = {32'h1c000030, 32'h00100823};
    step(); advance();
    idle(); EX_dest = 1; EX_is_load = 1; step();
    check("t5_bubble", ID_to_EX_valid, 0);
    advance();
    idle(); MEM_dest = 1; MEM_fwd = 32'h1234; step();
    check("t5_fire", ID_to_EX_valid, 1);
    check("t5_src1", to_EX_data[103:72], 32'h1234);
    advance();
`endif

    // bl held by EX back-pressure
    idle(); IF_to_ID_valid = 1; to_ID_data = {32'h1c000100, 32'h54004000};
    step(); advance();
    idle(); EX_allow_in = 0; step();
    held = to_EX_data;
    advance();
    for (int i = 0; i < 3; i++) begin
      idle(); EX_allow_in = 0; step();
      check("t6_hold_br", br_taken, 0);
      check("t6_hold_data", to_EX_data, held);
      advance();
    end
    idle(); step();
    check("t6_br_taken", br_taken, 1);
    check("t6_br_target", br_target, 32'h1c000140);
    check("t6_dest", to_EX_data[7:3], 1);
    check("t6_src1", to_EX_data[103:72], 32'h1c000100);
    check("t6_src2", to_EX_data[71:40], 4);
    advance();

    for (int c = 0; c < 3000; c++) begin
      for (int i = 1; i < 32; i++) regs[i] = (i <= 3) ? $urandom_range(7, 8) : $urandom;
      reset          = ($urandom_range(0, 99) == 0);
      IF_to_ID_valid = ($urandom_range(0, 3) != 0);
      EX_allow_in    = ($urandom_range(0, 3) != 0);
      EX_is_load     = 1'($urandom_range(0, 1));
      EX_dest        = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 3)) : 5'd0;
      MEM_dest       = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 3)) : 5'd0;
      WB_dest        = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 3)) : 5'd0;
      EX_fwd = $urandom; MEM_fwd = $urandom; WB_fwd = $urandom;
      rpc = $urandom;
      rpc[1:0] = 2'b00;
      to_ID_data = {rpc, gen_inst()};
      step();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
